// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, ALU op codes, decoded bundle and decoder.
// Latency: the decoder function is purely combinational.
// Backpressure: none here; flow control lives in decode_stage / decode_fifo.
package decode_pkg;

  localparam int IR_W = 16;

  // R-class opcodes, taken from ir[14:6]
  localparam logic [8:0] OP_NOP      = 9'h000;
  localparam logic [8:0] OP_SHIFT_LO = 9'h009;
  localparam logic [8:0] OP_SHIFT_HI = 9'h00E;
  localparam logic [8:0] OP_DENSE_HI = 9'h010;  // 0x00..0x10 are all defined
  localparam logic [8:0] OP_SHOW     = 9'h012;
  localparam logic [8:0] OP_SHOWRR   = 9'h013;
  localparam logic [8:0] OP_R14      = 9'h014;
  localparam logic [8:0] OP_CMP      = 9'h016;

  // J-class sub-opcodes, taken from ir[14:11]; 0..5 are the jumps, 6 is LDI
  localparam logic [3:0] JOP_JUMP = 4'd5;
  localparam logic [3:0] JOP_LDI  = 4'd6;

  // ALU op codes
  localparam logic [4:0] ALU_NOP   = 5'h00;
  localparam logic [4:0] ALU_JBASE = 5'h17;  // JE; JB..JUMP follow consecutively
  localparam logic [4:0] ALU_LDI   = 5'h1D;

  // Decoded instruction bundle as carried through the queue
  typedef struct packed {
    logic [2:0] addr1;
    logic [2:0] addr2;
    logic [2:0] addr_wr;
    logic [4:0] alu_op;
    logic       wr;
    logic       show;
    logic       show_rr;
    logic       jmp;
    logic       flag_wr;
    logic       illegal;
    logic [7:0] jmp_addr;
    logic [2:0] imm;
  } bundle_t;

  localparam int BUNDLE_W = $bits(bundle_t);

  // Decode one instruction word; every field not defined by the opcode stays zero
  function automatic bundle_t decode_ir(input logic [IR_W-1:0] ir);
    bundle_t    b;
    logic [8:0] op;
    logic [3:0] jop;
    logic       r_legal;
    b       = '0;
    op      = ir[14:6];
    jop     = ir[14:11];
    r_legal = (op <= OP_DENSE_HI) || (op == OP_SHOW) || (op == OP_SHOWRR) ||
              (op == OP_R14) || (op == OP_CMP);
    if (ir[15]) begin
      if (jop <= JOP_JUMP) begin
        b.alu_op   = ALU_JBASE + {1'b0, jop};
        b.jmp      = 1'b1;
        b.flag_wr  = 1'b1;
        b.jmp_addr = ir[7:0];
      end else if (jop == JOP_LDI) begin
        b.alu_op   = ALU_LDI;
        b.wr       = 1'b1;
        b.flag_wr  = 1'b1;
        b.addr_wr  = ir[10:8];
        b.jmp_addr = ir[7:0];
      end else begin
        b.alu_op  = ALU_NOP;
        b.illegal = 1'b1;
      end
    end else if (r_legal) begin
      b.alu_op  = op[4:0];
      b.addr1   = ir[5:3];
      b.addr2   = ir[2:0];
      b.addr_wr = ir[5:3];
      b.wr      = !((op == OP_NOP) || (op == OP_SHOW) || (op == OP_SHOWRR) || (op == OP_CMP));
      b.show    = (op == OP_SHOW);
      b.show_rr = (op == OP_SHOWRR);
      b.flag_wr = !((op == OP_SHOW) || (op == OP_SHOWRR));
      if ((op >= OP_SHIFT_LO) && (op <= OP_SHIFT_HI)) begin
        b.imm = ir[2:0];
      end
    end else begin
      b.alu_op  = ALU_NOP;
      b.illegal = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Small circular queue of decoded bundles with flush.
// Latency: a pushed entry is visible at the head on the next cycle when the queue was empty.
// Backpressure: full blocks push; flush drops everything and blocks push/pop that cycle.
module decode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign head_dat = mem[rd_ptr];

  // Storage write; contents are never read while count says the slot is empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally modulo the power-of-2 depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes at accept and queues the bundle for the consumer.
// Latency: 1 cycle from accept to out_valid on an empty queue.
// Backpressure: ir_ready drops when the queue is full, during flush and during reset.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ir_valid,
  input  logic [IR_W-1:0]  ir,
  output logic             ir_ready,
  input  logic             flush,
  input  logic             ill_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       addr1,
  output logic [2:0]       addr2,
  output logic [2:0]       addr_wr,
  output logic [4:0]       alu_op,
  output logic             wr,
  output logic             show,
  output logic             show_rr,
  output logic             jmp,
  output logic             flag_wr,
  output logic             illegal,
  output logic [7:0]       jmp_addr,
  output logic [2:0]       imm,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  bundle_t dec_dat;
  bundle_t head_dat;
  bundle_t head_q;
  logic    full;
  logic    empty;
  logic    push_vld;
  logic    pop_vld;
  logic    ill_accept;

  assign dec_dat    = decode_ir(ir);
  assign ir_ready   = rst_n && !full && !flush;
  assign push_vld   = ir_valid && ir_ready;
  assign out_valid  = !empty;
  assign pop_vld    = out_valid && out_ready;
  assign ill_accept = push_vld && dec_dat.illegal;

  decode_fifo #(
    .WIDTH (BUNDLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push_vld),
    .push_dat (dec_dat),
    .pop      (pop_vld),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty)
  );

  // Head fields read zero whenever there is no valid entry (including reset)
  assign head_q   = out_valid ? head_dat : '0;
  assign addr1    = head_q.addr1;
  assign addr2    = head_q.addr2;
  assign addr_wr  = head_q.addr_wr;
  assign alu_op   = head_q.alu_op;
  assign wr       = head_q.wr;
  assign show     = head_q.show;
  assign show_rr  = head_q.show_rr;
  assign jmp      = head_q.jmp;
  assign flag_wr  = head_q.flag_wr;
  assign illegal  = head_q.illegal;
  assign jmp_addr = head_q.jmp_addr;
  assign imm      = head_q.imm;

  // Saturating illegal counter; a same-cycle illegal accept wins over clear and counts as one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (ill_accept) begin
      if (ill_clr) begin
        ill_cnt <= CNT_ONE;
      end else if (ill_cnt != CNT_MAX) begin
        ill_cnt <= ill_cnt + CNT_ONE;
      end
    end else if (ill_clr) begin
      ill_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        ir_valid;
  logic [15:0] ir;
  logic        ir_ready;
  logic        flush;
  logic        ill_clr;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  addr1, addr2, addr_wr, imm;
  logic [4:0]  alu_op;
  logic        wr, show, show_rr, jmp, flag_wr, illegal;
  logic [7:0]  jmp_addr;
  logic [7:0]  ill_cnt;
  logic [30:0] obs;

  int checks;
  int failures;

  decode_stage #(.DEPTH(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_valid  (ir_valid),
    .ir        (ir),
    .ir_ready  (ir_ready),
    .flush     (flush),
    .ill_clr   (ill_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .addr1     (addr1),
    .addr2     (addr2),
    .addr_wr   (addr_wr),
    .alu_op    (alu_op),
    .wr        (wr),
    .show      (show),
    .show_rr   (show_rr),
    .jmp       (jmp),
    .flag_wr   (flag_wr),
    .illegal   (illegal),
    .jmp_addr  (jmp_addr),
    .imm       (imm),
    .ill_cnt   (ill_cnt)
  );

  assign obs = {addr1, addr2, addr_wr, alu_op, wr, show, show_rr, jmp, flag_wr, illegal, jmp_addr, imm};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected head bundle packed in the same order as obs
  function automatic logic [30:0] exp_b(input logic [2:0] a1, input logic [2:0] a2,
                                        input logic [2:0] aw, input logic [4:0] op,
                                        input logic w, input logic sh, input logic shr,
                                        input logic j, input logic fw, input logic il,
                                        input logic [7:0] ja, input logic [2:0] im);
    return {a1, a2, aw, op, w, sh, shr, j, fw, il, ja, im};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (ir_ready !== 1'b0) begin failures++; $display("FAIL reset_ir_ready got=%b exp=0", ir_ready); end
    checks++; if (ill_cnt !== 8'd0) begin failures++; $display("FAIL reset_ill_cnt got=%0d exp=0", ill_cnt); end
    checks++; if (obs !== 31'd0) begin failures++; $display("FAIL reset_bundle got=%h exp=0", obs); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    checks++; if (ir_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ir_ready got=%b exp=1", ir_ready); end
  endtask

  task automatic test_add();
    logic [30:0] e;
    e = exp_b(3'd1, 3'd0, 3'd1, 5'h01, 1, 0, 0, 0, 1, 0, 8'h00, 3'd0);
    out_ready = 1'b0; ir = 16'h0048; ir_valid = 1'b1;
    cyc();
    ir_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
    checks++; if (obs !== e) begin failures++; $display("FAIL add_bundle got=%h exp=%h", obs, e); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_pop_out_valid got=%b exp=0", out_valid); end
    checks++; if (obs !== 31'd0) begin failures++; $display("FAIL add_empty_bundle got=%h exp=0", obs); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vir [8];
    logic [30:0] vex [8];
    vir[0] = 16'hB3A5; vex[0] = exp_b(0, 0, 3, 5'h1D, 1, 0, 0, 0, 1, 0, 8'hA5, 0);
    vir[1] = 16'h80C3; vex[1] = exp_b(0, 0, 0, 5'h17, 0, 0, 0, 1, 1, 0, 8'hC3, 0);
    vir[2] = 16'hA87E; vex[2] = exp_b(0, 0, 0, 5'h1C, 0, 0, 0, 1, 1, 0, 8'h7E, 0);
    vir[3] = 16'h0495; vex[3] = exp_b(2, 5, 2, 5'h12, 0, 1, 0, 0, 0, 0, 8'h00, 0);
    vir[4] = 16'h029E; vex[4] = exp_b(3, 6, 3, 5'h0A, 1, 0, 0, 0, 1, 0, 8'h00, 6);
    vir[5] = 16'h0589; vex[5] = exp_b(1, 1, 1, 5'h16, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    vir[6] = 16'h04CB; vex[6] = exp_b(1, 3, 1, 5'h13, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    vir[7] = 16'h0048; vex[7] = exp_b(1, 0, 1, 5'h01, 1, 0, 0, 0, 1, 0, 8'h00, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ir = vir[i]; ir_valid = 1'b1;
      checks++; if (ir_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, ir_ready); end
      cyc();
      checks++; if (obs !== vex[i] || out_valid !== 1'b1) begin
        failures++; $display("FAIL b2b_bundle[%0d] ir=%h got=%h vld=%b exp=%h", i, vir[i], obs, out_valid, vex[i]);
      end
    end
    ir_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    checks++; if (ill_cnt !== 8'd0) begin failures++; $display("FAIL b2b_ill_cnt got=%0d exp=0", ill_cnt); end
  endtask

  task automatic test_illegal();
    logic [30:0] e;
    e = exp_b(0, 0, 0, 5'h00, 0, 0, 0, 0, 0, 1, 8'h00, 0);
    out_ready = 1'b0;
    ir = 16'hF800; ir_valid = 1'b1;
    cyc();
    ir = 16'h0440;
    cyc();
    ir_valid = 1'b0;
    checks++; if (ill_cnt !== 8'd2) begin failures++; $display("FAIL ill_cnt_two got=%0d exp=2", ill_cnt); end
    checks++; if (ir_ready !== 1'b0) begin failures++; $display("FAIL ill_full_ready got=%b exp=0", ir_ready); end
    checks++; if (obs !== e) begin failures++; $display("FAIL ill_head0 got=%h exp=%h", obs, e); end
    out_ready = 1'b1;
    cyc();
    checks++; if (obs !== e || out_valid !== 1'b1) begin failures++; $display("FAIL ill_head1 got=%h vld=%b exp=%h", obs, out_valid, e); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ill_drain got=%b exp=0", out_valid); end
    ir = 16'hFFFF; ir_valid = 1'b1; ill_clr = 1'b1;
    cyc();
    ir_valid = 1'b0; ill_clr = 1'b0;
    checks++; if (ill_cnt !== 8'd1) begin failures++; $display("FAIL ill_clr_with_accept got=%0d exp=1", ill_cnt); end
    cyc();
    ill_clr = 1'b1;
    cyc();
    ill_clr = 1'b0;
    out_ready = 1'b0;
    checks++; if (ill_cnt !== 8'd0) begin failures++; $display("FAIL ill_clr got=%0d exp=0", ill_cnt); end
  endtask

  task automatic test_full();
    logic [30:0] ea, eb, ec;
    ea = exp_b(1, 0, 1, 5'h01, 1, 0, 0, 0, 1, 0, 8'h00, 0);
    eb = exp_b(2, 1, 2, 5'h01, 1, 0, 0, 0, 1, 0, 8'h00, 0);
    ec = exp_b(3, 2, 3, 5'h01, 1, 0, 0, 0, 1, 0, 8'h00, 0);
    out_ready = 1'b0;
    ir = 16'h0048; ir_valid = 1'b1;
    cyc();
    ir = 16'h0051;
    cyc();
    ir = 16'h005A;
    checks++; if (ir_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ir_ready); end
    cyc();
    checks++; if (obs !== ea || ir_ready !== 1'b0) begin failures++; $display("FAIL full_hold got=%h rdy=%b exp=%h", obs, ir_ready, ea); end
    out_ready = 1'b1;
    cyc();
    checks++; if (obs !== eb || ir_ready !== 1'b1) begin failures++; $display("FAIL full_pop1 got=%h rdy=%b exp=%h", obs, ir_ready, eb); end
    cyc();
    ir_valid = 1'b0;
    checks++; if (obs !== ec || out_valid !== 1'b1) begin failures++; $display("FAIL full_third got=%h vld=%b exp=%h", obs, out_valid, ec); end
    cyc();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    ir = 16'hF800; ir_valid = 1'b1;
    cyc();
    ir = 16'h0048;
    cyc();
    ir = 16'h80C3; flush = 1'b1;
    checks++; if (ir_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", ir_ready); end
    cyc();
    flush = 1'b0; ir_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", out_valid); end
    checks++; if (ill_cnt !== 8'd1) begin failures++; $display("FAIL flush_ill_cnt got=%0d exp=1", ill_cnt); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_enqueue got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    logic [30:0] e;
    e = exp_b(1, 0, 1, 5'h01, 1, 0, 0, 0, 1, 0, 8'h00, 0);
    ir = 16'h0048; ir_valid = 1'b1;
    cyc();
    ir_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
    checks++; if (ill_cnt !== 8'd0) begin failures++; $display("FAIL areset_ill_cnt got=%0d exp=0", ill_cnt); end
    checks++; if (ir_ready !== 1'b0 || obs !== 31'd0) begin failures++; $display("FAIL areset_outputs rdy=%b bundle=%h exp=0", ir_ready, obs); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_discard got=%b exp=0", out_valid); end
    ir = 16'h0048; ir_valid = 1'b1;
    cyc();
    ir_valid = 1'b0;
    checks++; if (obs !== e || out_valid !== 1'b1) begin failures++; $display("FAIL areset_first_accept got=%h vld=%b exp=%h", obs, out_valid, e); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; ir_valid = 1'b0; ir = 16'h0000; flush = 1'b0; ill_clr = 1'b0; out_ready = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_full();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning decoded-entry queue depth (power of 2, 2..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning illegal-instruction counter width.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port ir_valid  in  1  meaning an instruction is offered.
REQ-006 SHALL have port ir  in  16  meaning the instruction word.
REQ-007 SHALL have port ir_ready  out  1  meaning the block accepts ir this cycle.
REQ-008 SHALL have port flush  in  1  meaning discard all queued and offered instructions.
REQ-009 SHALL have port ill_clr  in  1  meaning clear the illegal counter.
REQ-010 SHALL have port out_valid  out  1  meaning the head entry is valid.
REQ-011 SHALL have port out_ready  in  1  meaning the consumer takes the head entry.
REQ-012 SHALL have the head-entry ports addr1, addr2, addr_wr (out, 3 each), alu_op (out, 5), wr, show, show_rr, jmp, flag_wr, illegal (out, 1 each), jmp_addr (out, 8) and imm (out, 3).
REQ-013 SHALL have port ill_cnt  out  CNT_W  meaning a saturating count of accepted illegal instructions.

Function
REQ-014 SHALL accept an instruction when ir_valid && ir_ready; ir_ready = !full && !flush.
REQ-015 SHALL decode combinationally at accept and write the full bundle into the queue; an empty queue gives out_valid=1 on the next cycle (latency 1).
REQ-016 SHALL pop the head when out_valid && out_ready; a simultaneous push and pop on a full queue is not allowed (ir_ready is already 0).
REQ-017 SHALL zero every bundle field that an opcode does not define; no field may hold a value from an earlier instruction.
REQ-018 J-class decode (ir[15]=1, ir[14:11]=0..5: JE, JB, JA, JL, JG, JUMP) SHALL set alu_op=0x17+ir[14:11], jmp=1, flag_wr=1, wr=0 and jmp_addr=ir[7:0].
REQ-019 LDI decode (ir[15]=1, ir[14:11]=6) SHALL set alu_op=0x1D, wr=1, flag_wr=1, addr_wr=ir[10:8] and jmp_addr=ir[7:0] (the immediate).
REQ-020 R-class decode (ir[15]=0, op=ir[14:6] in 0x00..0x10, 0x12, 0x13, 0x14, 0x16) SHALL set alu_op=op[4:0], addr1=ir[5:3], addr2=ir[2:0] and addr_wr=ir[5:3].
REQ-021 R-class wr SHALL be 1 except for NOP 0x00, SHOW 0x12, SHOWRR 0x13 and CMP 0x16.
REQ-022 R-class show SHALL be 1 only for 0x12; show_rr SHALL be 1 only for 0x13; flag_wr SHALL be 1 except for 0x12 and 0x13.
REQ-023 For shift/rotate ops 0x09..0x0E, imm SHALL be ir[2:0]; for all other ops imm SHALL be 0.
REQ-024 Every other encoding SHALL enqueue as NOP with illegal=1 and wr, jmp and flag_wr at 0.
REQ-025 ill_cnt SHALL increment on each accepted illegal instruction and saturate at 2^CNT_W-1.
REQ-026 ill_clr together with an illegal accept in the same cycle SHALL give ill_cnt=1.
REQ-027 flush SHALL empty the queue on the next edge (out_valid=0), block the same-cycle push, and leave ill_cnt unchanged.
REQ-028 Queue pointers SHALL wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-029 rst_n=0 SHALL immediately clear the queue, pointers, count and ill_cnt, and drive out_valid=0.
REQ-030 During reset, all bundle outputs SHALL read 0 and ir_ready SHALL read 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries; the first accept after rst_n rises is ordinary.

Structure
REQ-032 A shared package decode_pkg SHALL hold the opcode constants, the ALU op codes and the decoded-bundle typedef.
REQ-033 The queue SHALL be a sub-module decode_fifo (parametrised width/DEPTH), instantiated once.

Verification
REQ-034 ir=0x0048 (ADD r1,r0) -> one cycle later: alu_op=0x01, addr1=1, addr2=0, addr_wr=1, wr=1, flag_wr=1, illegal=0.
REQ-035 ir=0xB3A5 (LDI r3,0xA5) -> alu_op=0x1D, addr_wr=3, jmp_addr=0xA5, wr=1, jmp=0, imm=0.
REQ-036 ir=0xF800, then 0x0440 -> two entries with illegal=1, NOP, wr=0; ill_cnt=2; pulse ill_clr -> 0.
REQ-037 DEPTH=2, out_ready=0, push 3 ADDs -> ir_ready=0 after 2 accepts; raise out_ready -> entries pop in order and the third is accepted.
REQ-038 Queue holds 2 entries, assert flush with ir_valid=1 -> next cycle out_valid=0 and the offered instruction is not enqueued.
REQ-039 Assert rst_n=0 asynchronously with 1 entry queued -> out_valid=0 and ill_cnt=0 at once, before any clock edge.
